// File: rtl/adder_pkg.sv
// Shared definitions for the adder/subtractor family: architecture ids,
// the clog2 helper and the serial subtractor FSM encodings.
package adder_pkg;

  localparam int ARCH_SERIAL = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_sub_chunk.sv
// One CHUNK_W-bit slice of the serial subtractor: d = a + ~b + cin.
module serial_sub_chunk #(
  parameter int CHUNK_W = 4
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] d,
  output logic               cout
);

  logic [CHUNK_W:0] sum;

  assign sum  = {1'b0, a} + {1'b0, ~b} + {{CHUNK_W{1'b0}}, cin};
  assign d    = sum[CHUNK_W-1:0];
  assign cout = sum[CHUNK_W];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle A - B, CHUNK_W bits per clock LSB first, borrow chain kept as a
// carry register in A + ~B + 1 form. One operation in flight at a time.
module serial_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CHUNK_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE and the
  // result holds until out_ready is seen.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int CNT_W  = clog2(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  if (WIDTH < 2) begin : g_width_check
    $fatal(1, "serial_subtractor: WIDTH must be >= 2");
  end
  if (WIDTH % CHUNK_W != 0) begin : g_chunk_check
    $fatal(1, "serial_subtractor: WIDTH must be a multiple of CHUNK_W");
  end

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   res;
  logic               carry;
  logic               sa;
  logic               sb;

  logic [CHUNK_W-1:0] chunk_d;
  logic               chunk_cout;
  logic [WIDTH-1:0]   res_next;

  serial_sub_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
    .a    (a_sh[CHUNK_W-1:0]),
    .b    (b_sh[CHUNK_W-1:0]),
    .cin  (carry),
    .d    (chunk_d),
    .cout (chunk_cout)
  );

  // New chunks enter from the MSB side so after NCHUNK steps res is aligned.
  if (NCHUNK == 1) begin : g_res_single
    assign res_next = chunk_d;
  end else begin : g_res_shift
    assign res_next = {chunk_d, res[WIDTH-1:CHUNK_W]};
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      carry      <= 1'b0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      out_diff   <= '0;
      out_borrow <= 1'b0;
      out_ovf    <= 1'b0;
      out_zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            sa    <= in_a[WIDTH-1];
            sb    <= in_b[WIDTH-1];
            carry <= 1'b1;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> CHUNK_W;
          b_sh  <= b_sh >> CHUNK_W;
          res   <= res_next;
          carry <= chunk_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            out_diff   <= res_next;
            out_borrow <= ~chunk_cout;
            out_ovf    <= (sa != sb) && (res_next[WIDTH-1] != sa);
            out_zero   <= (res_next == '0);
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle subtractor that computes A - B, processing CHUNK_W bits per clock from LSB to MSB with a borrow chain held in a register. It complements the parallel adder architectures in adder_pkg. It is the area-minimal "other direction" datapath used where throughput is not critical. Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
WIDTH, 32, operand and result width in bits; must be >= 2.
CHUNK_W, 4, bits processed per cycle; WIDTH % CHUNK_W must be 0 (elaboration-time check, fatal on violation).
NCHUNK, WIDTH/CHUNK_W, derived localparam; cycles per operation.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  operands valid.
in_ready  out  1  block can accept operands.
in_a  in  WIDTH  minuend.
in_b  in  WIDTH  subtrahend.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_diff  out  WIDTH  A - B modulo 2^WIDTH.
out_borrow  out  1  unsigned borrow (A < B unsigned).
out_ovf  out  1  two's-complement signed overflow.
out_zero  out  1  out_diff == 0.
busy  out  1  state != IDLE.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_diff=0, out_borrow=0, out_ovf=0, out_zero=0, busy=0. FSM goes to IDLE, chunk counter=0, borrow register=0. Reset asserted in any state aborts the operation; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid&&in_ready at edge T: latch in_a/in_b into shift registers, save sign bits a[WIDTH-1] and b[WIDTH-1], carry reg=1 (A + ~B + 1 form), counter=0, go to RUN.
  - RUN: each cycle, chunk = a_sh[CHUNK_W-1:0] + ~b_sh[CHUNK_W-1:0] + carry. Shift the chunk into the result register from the MSB side. Shift a_sh and b_sh right by CHUNK_W. Carry reg = chunk carry-out. Counter increments. When counter == NCHUNK-1, go to DONE.
  - DONE: out_valid=1. Outputs are stable until out_valid&&out_ready. On that handshake go to IDLE.
- Latency: accept at edge T; out_valid rises after edge T+NCHUNK.
- in_ready=0 in RUN and DONE; in_valid is ignored there. There is no same-cycle result-accept/new-operand overlap: in_ready rises the cycle after the output handshake. Throughput is one op per NCHUNK+2 cycles minimum.
- Flag rules:
  - out_borrow = ~final carry.
  - out_ovf = (sa != sb) && (out_diff[WIDTH-1] != sa).
  - out_zero is computed from the full result.
  - All flags are registered together with out_diff in the same edge that enters DONE.
- Counter width: adder_pkg::clog2(NCHUNK), minimum 1 bit.
- Inputs in_a/in_b may change freely after acceptance; the result depends only on values captured at the accept edge.
- out_ready high while out_valid=0 has no effect.
- Back-pressure: DONE holds indefinitely with all outputs stable.

Decomposition:
- adder_pkg: add localparam ARCH_SERIAL = 5. Reuse clog2 for the counter width.
- Sub-module serial_sub_chunk: combinational CHUNK_W-bit slice with inputs a, b, cin and outputs d, cout, implementing a + ~b + cin.
- The top block holds the FSM, shift registers, carry register and output registers.

Test Plan:
WIDTH=8, CHUNK_W=2 (NCHUNK=4) for all scenarios below.
- Basic: a=0x05, b=0x03 -> diff=0x02, borrow=0, ovf=0, zero=0. out_valid rises exactly 4 cycles after the accept edge.
- Unsigned underflow: a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0, zero=0.
- Signed overflow: a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
- Zero: a=0x2A, b=0x2A -> diff=0x00, zero=1, borrow=0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 with new operands. Required: outputs stable, in_ready=0, second op not accepted until the cycle after the out handshake. Then the second result is correct.
- Reset mid-RUN: assert rst asynchronously after 2 chunks. Required: immediately out_valid=0, busy=0, in_ready=1. The next op a=0xFF, b=0x01 -> 0xFE with no leftover carry.
